// File: rtl/dmem_resp.sv
// dmem_resp: single-outstanding data-memory responder with byte strobes and fixed wait latency
module dmem_resp #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] W_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH_WORDS];
    logic            w_accept;
    logic            w_err;
    logic [AW-1:0]   w_idx;

    // Acceptance is blocked during reset so memory cannot be written while rst is held.
    assign w_accept  = req_valid && (r_state == IDLE) && !rst;
    assign w_err     = (|req_addr[1:0]) || (|req_addr[31:AW+2]);
    assign w_idx     = req_addr[AW+1:2];
    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = rsp_valid ? r_rdata : 32'd0;
    assign rsp_err   = rsp_valid && r_err;

    // Next-state: accept in IDLE, count out WAIT, hold RESP until the CPU takes it.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (r_cnt == W_LAST) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register; reset aborts any outstanding request immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Wait counter and response capture; load data is sampled at the acceptance edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_cnt <= (r_state == WAIT && w_next == WAIT) ? r_cnt + 4'd1 : 4'd0;
            if (w_accept) begin
                r_err   <= w_err;
                r_rdata <= (req_we || w_err) ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    // Byte-lane store on acceptance; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err)
            for (int b = 0; b < 4; b++)
                if (req_wstrb[b]) r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed checks of dmem_resp with one zero-wait and one single-wait instance
module tb_dmem_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    // Drive a request while the DUT is idle and return just after the acceptance edge.
    task automatic issue(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_wstrb[d] = st;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
    endtask

    // Count edges from acceptance until rsp_valid is seen; bounded at 20.
    task automatic wait_rsp(input int d, output int lat);
        lat = 1;
        while (!rsp_valid[d] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume(input int d);
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
    endtask

    task automatic txn(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic er, output int lat);
        issue(d, we, a, wd, st);
        wait_rsp(d, lat);
        rd = rsp_rdata[d];
        er = rsp_err[d];
        consume(d);
    endtask

    task automatic test_reset;
        #3;
        checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready[1]); end
        checks++; if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid[1]); end
        checks++; if (rsp_rdata[1] !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata[1]); end
        checks++; if (rsp_err[1] !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err[1]); end
        checks++; if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_w0 got ready=%b valid=%b want 1 0", req_ready[0], rsp_valid[0]); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_store_load;
        logic [31:0] rd; logic er; int lat;
        txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL store_latency got %0d want 2", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL store_rsp got err=%b rdata=%h want 0 0", er, rd); end
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency got %0d want 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got %h want deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err got %b want 0", er); end
    endtask

    task automatic test_byte_strobe;
        logic [31:0] rd; logic er; int lat;
        txn(1, 1'b1, 32'h10, 32'h000000AA, 4'h1, rd, er, lat);
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL strobe_lane0 got %h want deadbeaa", rd); end
        txn(1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL nostrobe_err got %b want 0", er); end
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL nostrobe_data got %h want deadbeaa", rd); end
        txn(1, 1'b1, 32'h3FC, 32'h55667788, 4'b0110, rd, er, lat);
        txn(1, 1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd[23:8] !== 16'h6677 || er !== 1'b0) begin errors++; $display("FAIL last_word got %h err=%b want xx6677xx err=0", rd, er); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat;
        txn(1, 1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL misaligned_load got err=%b rdata=%h want 1 0", er, rd); end
        txn(1, 1'b0, 32'h400, 32'h0, 4'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL range_load got err=%b rdata=%h want 1 0", er, rd); end
        txn(1, 1'b1, 32'h12, 32'h11111111, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL misaligned_store got err=%b want 1", er); end
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEAA || er !== 1'b0) begin errors++; $display("FAIL err_store_nowrite got %h err=%b want deadbeaa 0", rd, er); end
    endtask

    task automatic test_backpressure;
        int lat;
        issue(1, 1'b0, 32'h10, 32'h0, 4'h0);
        wait_rsp(1, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hDEADBEAA || req_ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d got valid=%b rdata=%h ready=%b want 1 deadbeaa 0", i, rsp_valid[1], rsp_rdata[1], req_ready[1]);
            end
        end
        consume(1);
        checks++; if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin errors++; $display("FAIL after_handshake got valid=%b ready=%b want 0 1", rsp_valid[1], req_ready[1]); end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd; logic er; int lat;
        txn(1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, rd, er, lat);
        issue(1, 1'b1, 32'h30, 32'h12345678, 4'hF);
        #2 rst = 1'b1;
        #1;
        checks++; if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin errors++; $display("FAIL async_abort got valid=%b ready=%b want 0 1", rsp_valid[1], req_ready[1]); end
        @(posedge clk); #1;
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h20; req_wdata[1] = 32'h0; req_wstrb[1] = 4'hF;
        @(posedge clk); #1;
        checks++; if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL in_reset got ready=%b valid=%b want 1 0", req_ready[1], rsp_valid[1]); end
        req_valid[1] = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL ghost_rsp_%0d got valid=%b want 0", i, rsp_valid[1]); end
        end
        txn(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL reset_blocks_store got %h want a5a5a5a5", rd); end
        txn(1, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL committed_store got %h want 12345678", rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic er; int lat;
        logic [31:0] vals [4] = '{32'h01020304, 32'hCAFEF00D, 32'h0BADBEEF, 32'h76543210};
        for (int i = 0; i < 4; i++) txn(0, 1'b1, 32'(4 * i), vals[i], 4'hF, rd, er, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL w0_latency got %0d want 1", lat); end
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== vals[i]) begin
                errors++;
                $display("FAIL b2b_rsp_%0d got valid=%b rdata=%h want 1 %h", i, rsp_valid[0], rsp_rdata[0], vals[i]);
            end
            if (i < 3) req_addr[0] = 32'(4 * (i + 1));
            else req_valid[0] = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_gap_%0d got valid=%b ready=%b want 0 1", i, rsp_valid[0], req_ready[0]);
            end
        end
        rsp_ready[0] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
            req_wdata[d] = 32'h0; req_wstrb[d] = 4'h0; rsp_ready[d] = 1'b0;
        end
        test_reset;
        test_store_load;
        test_byte_strobe;
        test_errors;
        test_backpressure;
        test_reset_abort;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
